// File: rtl/formal_output_checker.sv
// Output scoreboard: compares fabric outputs against reference bench outputs over a
// fixed-length run, counting mismatch events and capturing the first failure.
module formal_output_checker #(
    parameter int unsigned NUM_CH      = 16,
    parameter int unsigned ERR_CNT_W   = 16,
    parameter int unsigned CYC_CNT_W   = 32,
    parameter int unsigned SKIP_CYCLES = 1,
    parameter int unsigned RUN_CYCLES  = 10,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_CH-1:0]    gfpga_out,
    input  logic [NUM_CH-1:0]    bench_out,
    input  logic [NUM_CH-1:0]    bench_valid,
    input  logic [NUM_CH-1:0]    ch_enable,
    output logic [NUM_CH-1:0]    mismatch_flag,
    output logic [NUM_CH-1:0]    mismatch_sticky,
    output logic [ERR_CNT_W-1:0] nb_error,
    output logic [CYC_CNT_W-1:0] first_err_cycle,
    output logic [CH_W-1:0]      first_err_ch,
    output logic                 busy,
    output logic                 done,
    output logic                 pass
);

    if (NUM_CH < 1 || RUN_CYCLES < 1) begin : g_bad_size
        $error("formal_output_checker: NUM_CH and RUN_CYCLES must be at least 1");
    end
    if (((RUN_CYCLES - 1) >> CYC_CNT_W) != 0) begin : g_bad_cyc_w
        $error("formal_output_checker: RUN_CYCLES-1 does not fit in CYC_CNT_W bits");
    end

    typedef enum logic [1:0] {IDLE, SKIP, CHECK, DONE} state_t;

    localparam int unsigned SUM_W = ERR_CNT_W + $clog2(NUM_CH + 1) + 1;
    localparam logic [SUM_W-1:0] ERR_MAX = (SUM_W'(1) << ERR_CNT_W) - SUM_W'(1);

    state_t               state;
    logic [31:0]          skip_cnt;
    logic [CYC_CNT_W-1:0] cyc_cnt;

    logic [NUM_CH-1:0]    miss;
    logic [NUM_CH-1:0]    rising;
    logic [SUM_W-1:0]     err_sum;
    logic [ERR_CNT_W-1:0] err_next;
    logic [CH_W-1:0]      low_ch;
    logic                 low_found;
    logic                 last_check;

    always_comb begin
        miss    = ch_enable & bench_valid & (gfpga_out ^ bench_out);
        rising  = miss & ~mismatch_flag;
        err_sum = SUM_W'(nb_error);
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            err_sum = err_sum + SUM_W'(rising[i]);
        end
        err_next = (err_sum > ERR_MAX) ? '1 : err_sum[ERR_CNT_W-1:0];

        low_ch    = '0;
        low_found = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (miss[i] && !low_found) begin
                low_ch    = CH_W'(i);
                low_found = 1'b1;
            end
        end
        last_check = (cyc_cnt == CYC_CNT_W'(RUN_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            skip_cnt        <= '0;
            cyc_cnt         <= '0;
            mismatch_flag   <= '0;
            mismatch_sticky <= '0;
            nb_error        <= '0;
            first_err_cycle <= '0;
            first_err_ch    <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        skip_cnt        <= '0;
                        cyc_cnt         <= '0;
                        mismatch_flag   <= '0;
                        mismatch_sticky <= '0;
                        nb_error        <= '0;
                        first_err_cycle <= '0;
                        first_err_ch    <= '0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        if (SKIP_CYCLES > 0) state <= SKIP;
                        else                 state <= CHECK;
                    end
                end
                SKIP: begin
                    skip_cnt <= skip_cnt + 32'd1;
                    if (skip_cnt == SKIP_CYCLES - 1) state <= CHECK;
                end
                CHECK: begin
                    nb_error        <= err_next;
                    mismatch_sticky <= mismatch_sticky | miss;
                    // An empty sticky vector means no mismatch has been seen yet this run.
                    if (mismatch_sticky == '0 && miss != '0) begin
                        first_err_cycle <= cyc_cnt;
                        first_err_ch    <= low_ch;
                    end
                    if (last_check) begin
                        state         <= DONE;
                        mismatch_flag <= '0;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        pass          <= (err_next == '0);
                    end else begin
                        mismatch_flag <= miss;
                        cyc_cnt       <= cyc_cnt + CYC_CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_formal_output_checker.sv
// Bench for formal_output_checker: directed vector table, hand-written reset/restart
// sequences and randomized runs checked against an event-counting reference model.
module tb_formal_output_checker;

    localparam int unsigned NCH  = 16;
    localparam int unsigned SKIP = 1;
    localparam int unsigned RUN  = 10;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [15:0] gfpga_out, bench_out, bench_valid, ch_enable;

    logic [15:0] mismatch_flag, mismatch_sticky, nb_error;
    logic [31:0] first_err_cycle;
    logic [3:0]  first_err_ch;
    logic        busy, done, pass;

    logic [15:0] s_flag, s_sticky;
    logic [1:0]  s_nb;
    logic [31:0] s_fec;
    logic [3:0]  s_fch;
    logic        s_busy, s_done, s_pass;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    formal_output_checker #(
        .NUM_CH(NCH), .ERR_CNT_W(16), .CYC_CNT_W(32), .SKIP_CYCLES(SKIP), .RUN_CYCLES(RUN)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .gfpga_out(gfpga_out), .bench_out(bench_out), .bench_valid(bench_valid), .ch_enable(ch_enable),
        .mismatch_flag(mismatch_flag), .mismatch_sticky(mismatch_sticky), .nb_error(nb_error),
        .first_err_cycle(first_err_cycle), .first_err_ch(first_err_ch),
        .busy(busy), .done(done), .pass(pass)
    );

    formal_output_checker #(
        .NUM_CH(NCH), .ERR_CNT_W(2), .CYC_CNT_W(32), .SKIP_CYCLES(SKIP), .RUN_CYCLES(RUN)
    ) u_sat (
        .clk(clk), .reset(reset), .start(start),
        .gfpga_out(gfpga_out), .bench_out(bench_out), .bench_valid(bench_valid), .ch_enable(ch_enable),
        .mismatch_flag(s_flag), .mismatch_sticky(s_sticky), .nb_error(s_nb),
        .first_err_cycle(s_fec), .first_err_ch(s_fch),
        .busy(s_busy), .done(s_done), .pass(s_pass)
    );

    typedef struct {
        logic [15:0] flip;
        logic [9:0]  cyc;
        logic [15:0] valid;
        logic [15:0] en;
        logic [15:0] skip_flip;
        int          bstart;
        int unsigned nb;
        logic [15:0] sticky;
        int unsigned fc;
        int unsigned fch;
        logic        pss;
        int unsigned sat_nb;
    } vec_t;

    vec_t tbl [10];

    // Stimulus for one run and the expectations it is compared against.
    logic [15:0] bv_a [RUN];
    logic [15:0] gv_a [RUN];
    logic [15:0] vv_a [RUN];
    logic [15:0] miss_a [RUN];
    logic [15:0] cur_en, cur_skf;
    int          cur_bstart;
    int unsigned exp_nb, exp_fc, exp_fch, exp_sat;
    logic [15:0] exp_sticky;
    logic        exp_pass;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic void compute_miss();
        for (int k = 0; k < RUN; k++) miss_a[k] = cur_en & vv_a[k] & (gv_a[k] ^ bv_a[k]);
    endfunction

    // Reference: an error event is the start of each maximal run of mismatching cycles per channel.
    function automatic void model();
        int unsigned cnt = 0;
        bit found = 1'b0;
        exp_sticky = '0;
        exp_fc = 0;
        exp_fch = 0;
        for (int ch = 0; ch < NCH; ch++)
            for (int k = 0; k < RUN; k++)
                if (miss_a[k][ch] && (k == 0 || !miss_a[k-1][ch])) cnt++;
        for (int k = 0; k < RUN; k++) begin
            exp_sticky |= miss_a[k];
            if (!found && miss_a[k] != 0) begin
                found  = 1'b1;
                exp_fc = k;
                for (int ch = NCH - 1; ch >= 0; ch--) if (miss_a[k][ch]) exp_fch = ch;
            end
        end
        exp_nb   = (cnt > 65535) ? 65535 : cnt;
        exp_sat  = (cnt > 3) ? 3 : cnt;
        exp_pass = (cnt == 0);
    endfunction

    task automatic run_one(input string nm);
        @(negedge clk);
        start       = 1'b1;
        ch_enable   = cur_en;
        bench_valid = '1;
        bench_out   = 16'($urandom);
        gfpga_out   = bench_out ^ cur_skf;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("%s busy_after_start", nm), 64'(busy), 64'(1));
        for (int s = 0; s < SKIP; s++) begin
            bench_out = 16'($urandom);
            gfpga_out = bench_out ^ cur_skf;
            @(negedge clk);
            chk($sformatf("%s skip_flag", nm), 64'(mismatch_flag), 64'(0));
        end
        for (int k = 0; k < RUN; k++) begin
            bench_out   = bv_a[k];
            gfpga_out   = gv_a[k];
            bench_valid = vv_a[k];
            start       = (k == cur_bstart);
            chk($sformatf("%s busy_c%0d", nm, k), 64'({busy, done}), 64'(2'b10));
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("%s flag_c%0d", nm, k), 64'(mismatch_flag),
                64'((k == RUN - 1) ? 16'h0 : miss_a[k]));
        end
        chk($sformatf("%s done", nm), 64'({busy, done}), 64'(2'b01));
        chk($sformatf("%s pass", nm), 64'(pass), 64'(exp_pass));
        chk($sformatf("%s nb_error", nm), 64'(nb_error), 64'(exp_nb));
        chk($sformatf("%s sticky", nm), 64'(mismatch_sticky), 64'(exp_sticky));
        chk($sformatf("%s first_cycle", nm), 64'(first_err_cycle), 64'(exp_fc));
        chk($sformatf("%s first_ch", nm), 64'(first_err_ch), 64'(exp_fch));
        chk($sformatf("%s sat_nb", nm), 64'(s_nb), 64'(exp_sat));
        chk($sformatf("%s sat_pass", nm), 64'({s_done, s_pass}), 64'({1'b1, exp_pass}));
        @(negedge clk);
        chk($sformatf("%s done_held", nm), 64'({done, nb_error}), 64'({1'b1, 16'(exp_nb)}));
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " flag"}, 64'(mismatch_flag), 64'(0));
        chk({nm, " sticky"}, 64'(mismatch_sticky), 64'(0));
        chk({nm, " nb_error"}, 64'(nb_error), 64'(0));
        chk({nm, " first"}, 64'({first_err_cycle, first_err_ch}), 64'(0));
        chk({nm, " status"}, 64'({busy, done, pass}), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{16'h0000, 10'h000, 16'hFFFF, 16'hFFFF, 16'h0000, -1, 0, 16'h0000, 0, 0, 1'b1, 0};
        tbl[1] = '{16'h0000, 10'h000, 16'hFFFF, 16'hFFFF, 16'h0000,  4, 0, 16'h0000, 0, 0, 1'b1, 0};
        tbl[2] = '{16'h0008, 10'h03C, 16'hFFFF, 16'hFFFF, 16'h0000, -1, 1, 16'h0008, 2, 3, 1'b0, 1};
        tbl[3] = '{16'h0001, 10'h02A, 16'hFFFF, 16'hFFFF, 16'h0000, -1, 3, 16'h0001, 1, 0, 1'b0, 3};
        tbl[4] = '{16'h0220, 10'h001, 16'hFFFF, 16'hFFFF, 16'h0000, -1, 2, 16'h0220, 0, 5, 1'b0, 2};
        tbl[5] = '{16'h0080, 10'h3FF, 16'hFF7F, 16'hFFFF, 16'h0000, -1, 0, 16'h0000, 0, 0, 1'b1, 0};
        tbl[6] = '{16'h0080, 10'h3FF, 16'hFFFF, 16'hFF7F, 16'h0000, -1, 0, 16'h0000, 0, 0, 1'b1, 0};
        tbl[7] = '{16'h0000, 10'h000, 16'hFFFF, 16'hFFFF, 16'hFFFF, -1, 0, 16'h0000, 0, 0, 1'b1, 0};
        tbl[8] = '{16'h0002, 10'h155, 16'hFFFF, 16'hFFFF, 16'h0000, -1, 5, 16'h0002, 0, 1, 1'b0, 3};
        tbl[9] = '{16'h0000, 10'h000, 16'hFFFF, 16'hFFFF, 16'h0000, -1, 0, 16'h0000, 0, 0, 1'b1, 0};

        reset = 1'b1; start = 1'b0;
        gfpga_out = '0; bench_out = '0; bench_valid = '0; ch_enable = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_all_zero("reset_state");

        // Reset during check cycle 4 after two counted events aborts the run.
        @(negedge clk);
        start = 1'b1; ch_enable = '1; bench_valid = '1;
        @(negedge clk);
        start = 1'b0;
        repeat (SKIP) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            bench_out = 16'($urandom);
            gfpga_out = bench_out ^ ((k == 0 || k == 2) ? 16'h0004 : 16'h0000);
            @(negedge clk);
        end
        chk("midrun nb_before_reset", 64'({busy, nb_error}), 64'({1'b1, 16'd2}));
        bench_out = 16'($urandom);
        gfpga_out = ~bench_out;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_all_zero("midrun_reset");
        @(negedge clk);
        chk_all_zero("midrun_idle");

        for (int t = 0; t < 10; t++) begin
            cur_en     = tbl[t].en;
            cur_skf    = tbl[t].skip_flip;
            cur_bstart = tbl[t].bstart;
            for (int k = 0; k < RUN; k++) begin
                bv_a[k] = 16'($urandom);
                gv_a[k] = bv_a[k] ^ (tbl[t].cyc[k] ? tbl[t].flip : 16'h0000);
                vv_a[k] = tbl[t].valid;
            end
            compute_miss();
            exp_nb     = tbl[t].nb;
            exp_sticky = tbl[t].sticky;
            exp_fc     = tbl[t].fc;
            exp_fch    = tbl[t].fch;
            exp_pass   = tbl[t].pss;
            exp_sat    = tbl[t].sat_nb;
            run_one($sformatf("vec%0d", t));
        end

        for (int r = 0; r < 30; r++) begin
            cur_en     = ($urandom_range(3) == 0) ? 16'($urandom) : 16'hFFFF;
            cur_skf    = 16'($urandom);
            cur_bstart = ($urandom_range(1) == 0) ? -1 : int'($urandom_range(RUN - 1));
            for (int k = 0; k < RUN; k++) begin
                bv_a[k] = 16'($urandom);
                gv_a[k] = bv_a[k] ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
                vv_a[k] = 16'($urandom) | 16'($urandom);
            end
            compute_miss();
            model();
            run_one($sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
